// File: rtl/ldq_cam_ctrl.sv
// ldq_cam_ctrl: load-queue CAM sequencer with allocation/commit, load-address writes and round-robin store search
//   clk/reset      : clock, asynchronous active-high reset
//   alloc_*        : tail allocation, ready when not full, tail pointer for store snapshots
//   commit_i       : retire head entry; flush_i: discard everything
//   count_o        : occupied entries
//   ld_wr_*        : executed-load address tag write, routed to the CAM write port
//   st_*           : two store search requesters, tag + tail snapshot, one-hot grant
//   resp_*         : registered age-masked violation vector, hit and oldest violating index
//   cam_*          : CAM search tag / match vector and write port
module ldq_cam_ctrl #(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_i,
    output logic             alloc_ready_o,
    output logic [INDEX:0]   alloc_ptr_o,
    input  logic             commit_i,
    input  logic             flush_i,
    output logic [INDEX:0]   count_o,
    input  logic             ld_wr_i,
    input  logic [INDEX-1:0] ld_wr_idx_i,
    input  logic [WIDTH-1:0] ld_wr_tag_i,
    input  logic [1:0]       st_req_i,
    input  logic [WIDTH-1:0] st_tag0_i,
    input  logic [WIDTH-1:0] st_tag1_i,
    input  logic [INDEX:0]   st_snap0_i,
    input  logic [INDEX:0]   st_snap1_i,
    output logic [1:0]       st_gnt_o,
    output logic             resp_valid_o,
    output logic             resp_port_o,
    output logic [DEPTH-1:0] resp_vect_o,
    output logic             resp_hit_o,
    output logic [INDEX-1:0] resp_idx_o,
    output logic [WIDTH-1:0] cam_tag_o,
    input  logic [DEPTH-1:0] cam_vect_i,
    output logic             cam_we_o,
    output logic [INDEX-1:0] cam_addr_o,
    output logic [WIDTH-1:0] cam_data_o
);
    logic [INDEX:0]   head_q, head_d, tail_q, tail_d, count, span, snap;
    logic [DEPTH-1:0] valid_q, valid_d, av_q, av_d, byp, young, vect;
    logic [INDEX-1:0] oldest;
    logic [WIDTH-1:0] tag;
    logic [1:0]       req, gnt;
    logic             full, commit_ok, alloc_ok, we, sel, rr_q, rr_d;
    logic             resp_valid_q, resp_port_q;
    logic [DEPTH-1:0] resp_vect_q;
    logic [INDEX-1:0] resp_idx_q;

    assign count     = tail_q - head_q;
    assign full      = count == (INDEX+1)'(DEPTH);
    assign commit_ok = commit_i & (count != '0);
    // when full, a same-cycle commit frees the slot the allocation reuses
    assign alloc_ok  = alloc_i & (~full | commit_ok);
    assign we        = ld_wr_i & valid_q[ld_wr_idx_i] & ~flush_i;

    assign req  = st_req_i & {2{~flush_i}};
    assign gnt  = &req ? (rr_q ? 2'b10 : 2'b01) : req;
    assign sel  = gnt[1];
    assign tag  = sel ? st_tag1_i : st_tag0_i;
    assign snap = sel ? st_snap1_i : st_snap0_i;
    assign rr_d = |gnt ? ~sel : rr_q;

    // same-cycle load write is not yet in the CAM, so it is forwarded here
    assign byp  = (we && ld_wr_tag_i == tag) ? (DEPTH'(1) << ld_wr_idx_i) : '0;
    assign span = tail_q - snap;
    assign vect = (cam_vect_i | byp) & valid_q & (av_q | byp) & young;

    always_comb begin
        young  = '0;
        oldest = '0;
        for (int i = 0; i < DEPTH; i++)
            young[i] = {1'b0, INDEX'(i) - snap[INDEX-1:0]} < span;
        // downward scan so the entry closest to the snapshot wins
        for (int k = DEPTH - 1; k >= 0; k--)
            if (vect[snap[INDEX-1:0] + INDEX'(k)]) oldest = snap[INDEX-1:0] + INDEX'(k);
    end

    always_comb begin
        valid_d = valid_q;
        av_d    = av_q;
        head_d  = flush_i ? '0 : head_q + {{INDEX{1'b0}}, commit_ok};
        tail_d  = flush_i ? '0 : tail_q + {{INDEX{1'b0}}, alloc_ok};
        if (we) av_d[ld_wr_idx_i] = 1'b1;
        if (commit_ok) begin
            valid_d[head_q[INDEX-1:0]] = 1'b0;
            av_d[head_q[INDEX-1:0]]    = 1'b0;
        end
        if (alloc_ok) begin
            valid_d[tail_q[INDEX-1:0]] = 1'b1;
            av_d[tail_q[INDEX-1:0]]    = 1'b0;
        end
        if (flush_i) begin
            valid_d = '0;
            av_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            av_q         <= '0;
            rr_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_vect_q  <= '0;
            resp_idx_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            av_q         <= av_d;
            rr_q         <= rr_d;
            resp_valid_q <= |gnt;
            resp_port_q  <= sel;
            resp_vect_q  <= |gnt ? vect : '0;
            resp_idx_q   <= |gnt ? oldest : '0;
        end
    end

    assign alloc_ready_o = ~full;
    assign alloc_ptr_o   = tail_q;
    assign count_o       = count;
    assign st_gnt_o      = gnt;
    assign cam_tag_o     = tag;
    assign cam_we_o      = we;
    assign cam_addr_o    = ld_wr_idx_i;
    assign cam_data_o    = ld_wr_tag_i;
    // a response landing while flush is asserted is stale and dropped
    assign resp_valid_o  = resp_valid_q & ~flush_i;
    assign resp_port_o   = resp_port_q;
    assign resp_vect_o   = resp_vect_q;
    assign resp_hit_o    = |resp_vect_q;
    assign resp_idx_o    = resp_idx_q;
endmodule
